fft_in_buf: RTL and testbench
=============================

Name: fft_in_buf

Overview:
- Ping-pong block buffer directly downstream of the pre-processing unit.
- Captures one block of 2^ldn complex samples in natural order after block_sync_i, then replays it to the radix-2 FFT core in bit-reversed order on request.
- Decouples the gapped pre-processing output stream from the gap-free FFT input; two banks allow fill of block k+1 while block k is read.

Parameters:
- DATA_WIDTH, 2*`FFT_IN_WIDTH, packed {real, imag} word stored per sample.
- MAX_LDN, 11, log2 of the largest block (2048 points).
- ADDR_WIDTH, MAX_LDN+1, RAM address width (bank bit + sample index).

Ports:
- clk_sys  in  1  system clock, all logic on rising edge.
- rst_sys_n  in  1  asynchronous active-low reset.
- block_sync_i  in  1  marks first sample of a block; valid only with data_val_i=1.
- data_val_i  in  1  input sample valid.
- data_real_i  in  `FFT_IN_WIDTH  signed real part.
- data_imag_i  in  `FFT_IN_WIDTH  signed imaginary part.
- ldn_rg_i  in  4  log2 block length, legal 3..MAX_LDN, sampled at block_sync_i.
- rd_req_i  in  1  downstream may accept a whole block.
- blk_rdy_o  out  1  a full bank is waiting to be read.
- ovf_o  out  1  one-cycle pulse: block dropped, no free bank.
- block_sync_o  out  1  coincident with first output sample.
- data_val_o  out  1  output sample valid.
- data_real_o  out  `FFT_IN_WIDTH  signed real part.
- data_imag_o  out  `FFT_IN_WIDTH  signed imaginary part.

Behaviour:
- Reset: every output 0, both banks empty, wr_bank=rd_bank=0, both FSMs idle. Reset mid-operation abandons all stored data.
- Storage: 2*2^MAX_LDN x DATA_WIDTH simple dual-port RAM, synchronous read (1 cycle); bank b occupies addresses b*2^MAX_LDN upward. Per-bank regs: full flag, ldn.
- Write FSM W_IDLE / W_FILL:
  - W_IDLE: samples without block_sync_i are discarded.
  - W_IDLE, block_sync_i & data_val_i & full[wr_bank]=0: latch ldn into the bank, write sample at index 0, wr_cnt=1, go to W_FILL.
  - W_IDLE, block_sync_i & data_val_i & full[wr_bank]=1: ovf_o=1 for one cycle, stay in W_IDLE, whole block dropped.
  - W_FILL: each data_val_i writes at index wr_cnt, wr_cnt increments; data_val_i=0 cycles are ignored.
  - W_FILL, write of index 2^ldn-1: set full[wr_bank], toggle wr_bank, go to W_IDLE.
  - W_FILL, block_sync_i: the partial block is discarded (bank not marked full) and the fill restarts at index 0 in the same bank with the newly latched ldn.
- Read FSM R_IDLE / R_RUN:
  - blk_rdy_o = full[rd_bank] (registered).
  - R_IDLE, rd_req_i & blk_rdy_o (accept cycle A): go to R_RUN; read index rd_cnt=0..2^ldn-1, one per cycle, from cycle A+1.
  - RAM address = bit-reverse of the low ldn bits of rd_cnt, using the bank's stored ldn.
  - Outputs are registered from the RAM: data_val_o high for exactly 2^ldn consecutive cycles starting at A+2; block_sync_o high on cycle A+2 only.
  - After the last address is issued: clear full[rd_bank], toggle rd_bank, return to R_IDLE. rd_req_i is ignored while in R_RUN.
  - data_real_o / data_imag_o = 0 whenever data_val_o=0.
- Timing: blk_rdy_o rises the cycle after the last sample of a block is written; minimum input-to-output latency is that cycle + 2.
- Simultaneous events:
  - Write completing on one bank while the other bank is being read: both proceed.
  - A bank release and a block_sync_i that finds that bank full in the same cycle: overflow, because full flags are registered and a release takes effect the next cycle.
  - Read and write never target the same bank at the same time.

Test Plan:
- ldn=3, 8 contiguous samples real=0..7, imag=-real, rd_req_i held high -> output real order 0,4,2,6,1,5,3,7 on 8 consecutive cycles; block_sync_o with the first; first output 2 cycles after blk_rdy_o rises.
- Same block with data_val_i toggling 1,0,1,0 -> identical output order and timing relative to blk_rdy_o.
- rd_req_i low, three ldn=4 blocks -> ovf_o single pulse at the third block_sync_i; then rd_req_i=1 -> blocks 1 and 2 delivered in order; block 3 never appears.
- ldn=4, block_sync_i at sample 5 of a fill, then a full 16-sample block -> only the second block is output; no ovf_o.
- ldn=11, continuous stream with rd_req_i high -> block 2 fills while block 1 is read; output index 1 carries input 1024, index 2047 carries input 2047; no gaps or ovf_o.
- rst_sys_n low mid-read -> all outputs 0 immediately (asynchronous); after release, blk_rdy_o=0 and the next ldn=3 block is output correctly.

Source files
------------

// File: rtl/fft_in_buf.sv
// Ping-pong block buffer: captures 2^ldn samples in natural order, replays them bit-reversed.
// Latency: first output 2 cycles after the read is accepted; blk_rdy_o rises 1 cycle after the last write.
// Backpressure: none on input (blocks are dropped with ovf_o when no bank is free); reads start only on rd_req_i.
`ifndef FFT_IN_WIDTH
`define FFT_IN_WIDTH 16
`endif

module fft_in_buf #(
    parameter int MAX_LDN = 11
) (
    input  logic                       clk_sys,
    input  logic                       rst_sys_n,
    input  logic                       block_sync_i,
    input  logic                       data_val_i,
    input  logic [`FFT_IN_WIDTH-1:0]   data_real_i,
    input  logic [`FFT_IN_WIDTH-1:0]   data_imag_i,
    input  logic [3:0]                 ldn_rg_i,
    input  logic                       rd_req_i,
    output logic                       blk_rdy_o,
    output logic                       ovf_o,
    output logic                       block_sync_o,
    output logic                       data_val_o,
    output logic [`FFT_IN_WIDTH-1:0]   data_real_o,
    output logic [`FFT_IN_WIDTH-1:0]   data_imag_o
);

    localparam int W          = `FFT_IN_WIDTH;
    localparam int DATA_WIDTH = 2 * W;
    localparam int ADDR_WIDTH = MAX_LDN + 1;
    localparam int DEPTH      = 1 << ADDR_WIDTH;

    localparam logic [0:0] W_IDLE = 1'b0;
    localparam logic [0:0] W_FILL = 1'b1;
    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_RUN  = 1'b1;

    logic [DATA_WIDTH-1:0] ram [0:DEPTH-1];
    logic [DATA_WIDTH-1:0] ram_q;

    logic [1:0]            full;
    logic [1:0][3:0]       bank_ldn;

    logic [0:0]            w_state;
    logic                  wr_bank;
    logic [MAX_LDN-1:0]    wr_cnt;
    logic [MAX_LDN-1:0]    wr_idx;
    logic [MAX_LDN-1:0]    wr_mask;
    logic                  wr_en;
    logic                  wr_start;
    logic                  wr_done;
    logic                  ovf_set;

    logic [0:0]            r_state;
    logic                  rd_bank;
    logic [MAX_LDN-1:0]    rd_cnt;
    logic [MAX_LDN-1:0]    rd_rev;
    logic [MAX_LDN-1:0]    rd_idx;
    logic [MAX_LDN-1:0]    rd_mask;
    logic [3:0]            rd_ldn;
    logic                  rd_en;
    logic                  rd_done;

    // Index of the last sample of a block, for the bank being filled / read
    assign wr_mask = ~({MAX_LDN{1'b1}} << bank_ldn[wr_bank]);
    assign rd_ldn  = bank_ldn[rd_bank];
    assign rd_mask = ~({MAX_LDN{1'b1}} << rd_ldn);

    // Write decode: a sync restarts a fill in the current bank, or overflows if that bank is still full
    always_comb begin
        wr_en    = 1'b0;
        wr_start = 1'b0;
        wr_idx   = '0;
        ovf_set  = 1'b0;
        if (data_val_i) begin
            if (block_sync_i) begin
                if (w_state == W_FILL || !full[wr_bank]) begin
                    wr_en    = 1'b1;
                    wr_start = 1'b1;
                end else begin
                    ovf_set  = 1'b1;
                end
            end else if (w_state == W_FILL) begin
                wr_en  = 1'b1;
                wr_idx = wr_cnt;
            end
        end
    end

    assign wr_done = wr_en && !wr_start && (wr_idx == wr_mask);

    // Write FSM: track fill position, latch block length on sync, hand the bank over when complete
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            w_state  <= W_IDLE;
            wr_bank  <= 1'b0;
            wr_cnt   <= '0;
            bank_ldn <= '0;
            ovf_o    <= 1'b0;
        end else begin
            ovf_o <= ovf_set;
            if (wr_start) begin
                bank_ldn[wr_bank] <= ldn_rg_i;
                wr_cnt            <= MAX_LDN'(1);
                w_state           <= W_FILL;
            end else if (wr_done) begin
                wr_cnt  <= '0;
                wr_bank <= ~wr_bank;
                w_state <= W_IDLE;
            end else if (wr_en) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

    // Bank ownership: the writer sets full on completion, the reader clears it after the last address
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            full <= 2'b00;
        end else begin
            if (wr_done) full[wr_bank] <= 1'b1;
            if (rd_done) full[rd_bank] <= 1'b0;
        end
    end

    assign blk_rdy_o = full[rd_bank];
    assign rd_en     = (r_state == R_RUN);
    assign rd_done   = rd_en && (rd_cnt == rd_mask);

    // Bit-reverse the full counter, then shift so only the low ldn bits are reversed
    always_comb begin
        rd_rev = '0;
        for (int i = 0; i < MAX_LDN; i++) begin
            rd_rev[i] = rd_cnt[MAX_LDN-1-i];
        end
        rd_idx = rd_rev >> (4'(MAX_LDN) - rd_ldn);
    end

    // Read FSM: one address per cycle for a whole block, then release the bank
    always_ff @(posedge clk_sys or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            r_state      <= R_IDLE;
            rd_bank      <= 1'b0;
            rd_cnt       <= '0;
            data_val_o   <= 1'b0;
            block_sync_o <= 1'b0;
        end else begin
            data_val_o   <= rd_en;
            block_sync_o <= rd_en && (rd_cnt == '0);
            if (r_state == R_IDLE) begin
                if (rd_req_i && blk_rdy_o) begin
                    r_state <= R_RUN;
                    rd_cnt  <= '0;
                end
            end else if (rd_done) begin
                r_state <= R_IDLE;
                rd_cnt  <= '0;
                rd_bank <= ~rd_bank;
            end else begin
                rd_cnt <= rd_cnt + 1'b1;
            end
        end
    end

    // Sample RAM: one write port, one registered read port acting as the output data register
    always_ff @(posedge clk_sys) begin
        if (wr_en) ram[{wr_bank, wr_idx}] <= {data_real_i, data_imag_i};
        ram_q <= ram[{rd_bank, rd_idx}];
    end

    // Data is forced to zero outside valid cycles, including immediately on reset
    assign data_real_o = data_val_o ? ram_q[DATA_WIDTH-1:W] : '0;
    assign data_imag_o = data_val_o ? ram_q[W-1:0]          : '0;

endmodule

// File: tb/tb_fft_in_buf.sv
`ifndef FFT_IN_WIDTH
`define FFT_IN_WIDTH 16
`endif

module tb_fft_in_buf;

    localparam int W = `FFT_IN_WIDTH;

    logic            clk_sys = 1'b0;
    logic            rst_sys_n;
    logic            block_sync_i, data_val_i, rd_req_i;
    logic [W-1:0]    data_real_i, data_imag_i;
    logic [3:0]      ldn_rg_i;
    logic            blk_rdy_o, ovf_o, block_sync_o, data_val_o;
    logic [W-1:0]    data_real_o, data_imag_o;

    fft_in_buf #(.MAX_LDN(11)) dut (
        .clk_sys(clk_sys), .rst_sys_n(rst_sys_n),
        .block_sync_i(block_sync_i), .data_val_i(data_val_i),
        .data_real_i(data_real_i), .data_imag_i(data_imag_i),
        .ldn_rg_i(ldn_rg_i), .rd_req_i(rd_req_i),
        .blk_rdy_o(blk_rdy_o), .ovf_o(ovf_o),
        .block_sync_o(block_sync_o), .data_val_o(data_val_o),
        .data_real_o(data_real_o), .data_imag_o(data_imag_o)
    );

    always #5 clk_sys = ~clk_sys;

    typedef struct {
        logic signed [W-1:0] re;
        logic signed [W-1:0] im;
        logic                sync;
    } exp_t;

    typedef struct {
        int ldn;
        int gap;
        int base;
        int exp_out1;
        int exp_last;
    } vec_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_pass = 0;
    int   ovf_seen = 0;
    int   out_idx = 0;
    int   out_log [0:2047];
    logic prev_val = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic int bitrev(input int k, input int ldn);
        int r = 0;
        for (int b = 0; b < ldn; b++) r = (r << 1) | ((k >> b) & 1);
        return r;
    endfunction

    function automatic void push_block(input int ldn, input int base);
        exp_t e;
        for (int k = 0; k < (1 << ldn); k++) begin
            e.re   = W'(base + bitrev(k, ldn));
            e.im   = W'(-(base + bitrev(k, ldn)));
            e.sync = (k == 0);
            sb.push_back(e);
        end
    endfunction

    // Drives n samples of a block; returns 1 ns after the edge that captures the last sample
    task automatic send_block(input int ldn, input int gap, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (gap != 0 && i != 0) begin
                data_val_i   = 1'b0;
                block_sync_i = 1'b0;
                repeat (gap) begin @(posedge clk_sys); #1; end
            end
            data_val_i   = 1'b1;
            block_sync_i = (i == 0);
            ldn_rg_i     = 4'(ldn);
            data_real_i  = W'(base + i);
            data_imag_i  = W'(-(base + i));
            @(posedge clk_sys); #1;
        end
        data_val_i   = 1'b0;
        block_sync_i = 1'b0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin @(negedge clk_sys); n++; end
        repeat (12) @(negedge clk_sys);
        chk({"drain_", name}, sb.size(), 0);
    endtask

    // Output monitor: scoreboard pop on every valid sample, zero check on idle cycles
    always @(negedge clk_sys) begin
        if (rst_sys_n) begin
            if (ovf_o) ovf_seen++;
            if (data_val_o) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    n_chk++;
                    if (data_real_o == mon_e.re && data_imag_o == mon_e.im &&
                        block_sync_o == mon_e.sync && (mon_e.sync || prev_val))
                        n_pass++;
                    else
                        $display("FAIL out_sample: got re=%0d im=%0d sync=%0d contig=%0d expected re=%0d im=%0d sync=%0d",
                                 $signed(data_real_o), $signed(data_imag_o), block_sync_o, prev_val,
                                 mon_e.re, mon_e.im, mon_e.sync);
                end
                if (block_sync_o) out_idx = 0;
                if (out_idx < 2048) out_log[out_idx] = int'($signed(data_real_o));
                out_idx++;
            end else begin
                chk("idle_zero", longint'({data_real_o, data_imag_o, block_sync_o}), 0);
            end
            prev_val = data_val_o;
        end
    end

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t vecs[4];
        int   ovf0, n;
        vecs[0] = '{ldn: 3, gap: 0, base:   0, exp_out1:   4, exp_last:   7};
        vecs[1] = '{ldn: 3, gap: 1, base:   0, exp_out1:   4, exp_last:   7};
        vecs[2] = '{ldn: 5, gap: 0, base: 100, exp_out1: 116, exp_last: 131};
        vecs[3] = '{ldn: 4, gap: 2, base: -50, exp_out1: -42, exp_last: -35};

        rst_sys_n = 1'b0; block_sync_i = 1'b0; data_val_i = 1'b0; rd_req_i = 1'b0;
        data_real_i = '0; data_imag_i = '0; ldn_rg_i = 4'd3;
        #1;
        chk("rst_blk_rdy", blk_rdy_o, 0);
        chk("rst_ovf", ovf_o, 0);
        chk("rst_sync", block_sync_o, 0);
        chk("rst_val", data_val_o, 0);
        chk("rst_real", data_real_o, 0);
        chk("rst_imag", data_imag_o, 0);
        @(negedge clk_sys); #1;
        rst_sys_n = 1'b1;
        rd_req_i  = 1'b1;

        // Table-driven blocks: order via scoreboard, plus timing and spot values
        for (int v = 0; v < 4; v++) begin
            ovf0 = ovf_seen;
            push_block(vecs[v].ldn, vecs[v].base);
            send_block(vecs[v].ldn, vecs[v].gap, vecs[v].base, 1 << vecs[v].ldn);
            @(negedge clk_sys);
            chk($sformatf("v%0d_blk_rdy_rise", v), blk_rdy_o, 1);
            n = 0;
            while (!block_sync_o && n < 20) begin @(negedge clk_sys); n++; end
            chk($sformatf("v%0d_latency", v), n, 2);
            wait_drain($sformatf("v%0d", v), 200);
            chk($sformatf("v%0d_out1", v), out_log[1], vecs[v].exp_out1);
            chk($sformatf("v%0d_out_last", v), out_log[(1 << vecs[v].ldn) - 1], vecs[v].exp_last);
            chk($sformatf("v%0d_no_ovf", v), ovf_seen - ovf0, 0);
        end

        // Both banks full, third block overflows and is never delivered
        rd_req_i = 1'b0;
        ovf0 = ovf_seen;
        push_block(4, 200);
        push_block(4, 300);
        send_block(4, 0, 200, 16);
        send_block(4, 0, 300, 16);
        @(negedge clk_sys);
        chk("ovf_before_third", ovf_seen - ovf0, 0);
        chk("ovf_blk_rdy", blk_rdy_o, 1);
        send_block(4, 0, 400, 16);
        @(negedge clk_sys);
        chk("ovf_pulse_count", ovf_seen - ovf0, 1);
        chk("ovf_no_output_yet", sb.size(), 32);
        rd_req_i = 1'b1;
        wait_drain("ovf", 300);
        chk("ovf_blk_rdy_after", blk_rdy_o, 0);

        // Sync inside a fill discards the partial block
        ovf0 = ovf_seen;
        send_block(4, 0, 500, 5);
        push_block(4, 600);
        send_block(4, 0, 600, 16);
        wait_drain("restart", 200);
        chk("restart_no_ovf", ovf_seen - ovf0, 0);
        chk("restart_out1", out_log[1], 608);

        // Max-length continuous stream: second block fills while the first is read
        ovf0 = ovf_seen;
        push_block(11, 0);
        push_block(11, 2048);
        send_block(11, 0, 0, 2048);
        send_block(11, 0, 2048, 2048);
        wait_drain("stream", 10000);
        chk("stream_no_ovf", ovf_seen - ovf0, 0);
        chk("stream_out1", out_log[1], 3072);
        chk("stream_out2047", out_log[2047], 4095);

        // Asynchronous reset in the middle of a read
        push_block(3, 700);
        send_block(3, 0, 700, 8);
        n = 0;
        while (!data_val_o && n < 20) begin @(negedge clk_sys); n++; end
        chk("mid_read_started", data_val_o, 1);
        @(negedge clk_sys);
        #2;
        rst_sys_n = 1'b0;
        #1;
        chk("arst_val", data_val_o, 0);
        chk("arst_sync", block_sync_o, 0);
        chk("arst_real", data_real_o, 0);
        chk("arst_imag", data_imag_o, 0);
        chk("arst_blk_rdy", blk_rdy_o, 0);
        sb.delete();
        prev_val = 1'b0;
        @(negedge clk_sys); @(negedge clk_sys); #1;
        rst_sys_n = 1'b1;
        @(negedge clk_sys);
        chk("post_rst_blk_rdy", blk_rdy_o, 0);
        push_block(3, 800);
        send_block(3, 0, 800, 8);
        wait_drain("post_rst", 200);
        chk("post_rst_out1", out_log[1], 804);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
